// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of one packed BCD digit
  localparam int BCD_DIGIT_W = 4;

  // Double-dabble correction: digits at or above the threshold get the
  // adjustment added before the shift so that the doubled value carries
  // into the next digit instead of landing on an illegal code 10..15.
  localparam logic [BCD_DIGIT_W-1:0] DABBLE_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] DABBLE_ADJ    = 4'd3;

endpackage : bcd_pkg

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready request and result bundle for the binary-to-BCD converter.
// Latency: n/a (wiring only).
// Backpressure: producer holds in_* until in_ready; converter holds result until out_ready.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  // Converter side
  modport slave (
    input  in_valid,
    input  in_bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd,
    output ovf
  );

  // Operand source / result sink side
  modport master (
    output in_valid,
    output in_bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd,
    input  ovf
  );

endinterface : bin2bcd_seq_if

// File: rtl/bcd_dabble_digit.sv
// One BCD digit of the shift-and-add-3 correction: add 3 when the digit is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Correct the digit ahead of the left shift; legal inputs are 0..9 so
  // the 4-bit sum never wraps.
  always_comb begin
    dout = din;
    if (din >= DABBLE_THRESH) begin
      dout = din + DABBLE_ADJ;
    end
  end

endmodule : bcd_dabble_digit

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Latency: accept at edge N -> out_valid after edge N+BIN_W; issue interval BIN_W+2.
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  io
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SH_W  = BCD_W + BIN_W;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q,   bin_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;

  // Digit-corrected BCD register and the combined shifted value
  logic [BCD_W-1:0]   bcd_adj;
  logic [SH_W-1:0]    shift_vec;

  // All digits are corrected in parallel from the registered BCD value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .din  (bcd_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The BCD and binary registers act as one long left shifter. Whatever
  // leaves the top digit would have formed digits beyond DIGITS, so any
  // such bit means the operand was at least 10^DIGITS.
  assign shift_vec = {bcd_adj, bin_q} << 1;

  // Next-state, datapath and counter control
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          bin_d   = io.in_bin;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        bcd_d = shift_vec[SH_W-1:BIN_W];
        bin_d = shift_vec[BIN_W-1:0];
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        cnt_d = cnt_q - CNT_W'(1);
        // Always runs the full BIN_W shifts, even for a zero operand,
        // so latency is data-independent.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake flags decode straight from state; result comes from the
  // registers, which are frozen while in DONE.
  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.bcd       = bcd_q;
  assign io.ovf       = ovf_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, a monitor pops and compares.
// Latency: checked as BIN_W edges from accept to out_valid.
// Backpressure: exercised by holding out_ready low while a result waits.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic        prev_valid = 1'b0;
  logic        pend_idle  = 1'b0;
  logic [15:0] held_bcd;
  logic        held_ovf;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) io ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one operand at the first negedge where in_ready is high, and
  // record the edge on which it will be accepted.
  task automatic issue(input logic [13:0] bin, input logic [15:0] eb, input logic eo);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!io.in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed %0b expected 1", io.in_ready);
    end
    io.in_bin   = bin;
    io.in_valid = 1'b1;
    e.bcd = eb;
    e.ovf = eo;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each new result and checks hold/release.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      pend_idle  = 1'b0;
    end else begin
      if (pend_idle) begin
        chk("released_out_valid", 32'(io.out_valid), 32'd0);
        chk("released_in_ready",  32'(io.in_ready),  32'd1);
        pend_idle = 1'b0;
      end
      if (io.out_valid) begin
        chk("in_ready_in_done", 32'(io.in_ready), 32'd0);
        if (!prev_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got bcd %h expected no result", io.bcd);
          end else begin
            e = q.pop_front();
            chk("bcd", 32'(io.bcd), 32'(e.bcd));
            chk("ovf", 32'(io.ovf), 32'(e.ovf));
            chk("latency", 32'(cyc - e.acc), 32'(BIN_W));
          end
          held_bcd = io.bcd;
          held_ovf = io.ovf;
        end else begin
          chk("bcd_stable", 32'(io.bcd), 32'(held_bcd));
          chk("ovf_stable", 32'(io.ovf), 32'(held_ovf));
        end
        if (io.out_ready) pend_idle = 1'b1;
      end
      prev_valid = io.out_valid;
    end
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_bin    = '0;
    io.out_ready = 1'b1;
    #1;
    chk("reset_in_ready",  32'(io.in_ready),  32'd1);
    chk("reset_out_valid", 32'(io.out_valid), 32'd0);
    chk("reset_bcd",       32'(io.bcd),       32'd0);
    chk("reset_ovf",       32'(io.ovf),       32'd0);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Basic conversion, then zero and all-nines back to back
    issue(14'd1234,  16'h1234, 1'b0);
    issue(14'd0,     16'h0000, 1'b0);
    issue(14'd9999,  16'h9999, 1'b0);
    // Overflow cases: top digit truncated
    issue(14'd16383, 16'h6383, 1'b1);
    issue(14'd10000, 16'h0000, 1'b1);
    issue(14'd7,     16'h0007, 1'b0);

    // Backpressure: result held for 20 cycles with out_ready low
    n = 0;
    while (!io.in_ready && n < 100) begin @(negedge clk); n++; end
    #1 io.out_ready = 1'b0;
    issue(14'd42, 16'h0042, 1'b0);
    n = 0;
    while (!io.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 32'(io.out_valid), 32'd1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(io.out_valid), 32'd1);
      chk("bp_hold_bcd",   32'(io.bcd),       32'h0042);
    end
    #1 io.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(io.out_valid), 32'd0);
    chk("bp_release_ready", 32'(io.in_ready),  32'd1);

    // Input churn while busy: only the accepted operand is converted
    issue(14'd4321, 16'h4321, 1'b0);
    n = 0;
    while (n < 40) begin
      if (io.out_valid) begin
        chk("churn_ready_done", 32'(io.in_ready), 32'd0);
        io.in_valid = 1'b0;
        break;
      end
      chk("churn_ready_shift", 32'(io.in_ready), 32'd0);
      io.in_valid = 1'b1;
      io.in_bin   = 14'($urandom_range(0, 16383));
      @(negedge clk);
      n++;
    end
    io.in_valid = 1'b0;

    // Reset in the 7th shift cycle discards the conversion
    issue(14'd5555, 16'h5555, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_bcd",       32'(io.bcd),       32'd0);
    chk("midreset_ovf",       32'(io.ovf),       32'd0);
    chk("midreset_out_valid", 32'(io.out_valid), 32'd0);
    chk("midreset_in_ready",  32'(io.in_ready),  32'd1);
    q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(14'd789, 16'h0789, 1'b0);

    // Drain the scoreboard
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bin2bcd_seq
